// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI-flash read engine.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StDone,
    StHold,
    StGap
  } main_state_e;

  typedef enum logic [1:0] {
    StIssue,
    StWaitLo,
    StWaitHi
  } byte_state_e;

  localparam logic [7:0]  CmdReadDefault = 8'h03;
  localparam logic [7:0]  DummyByte      = 8'h00;
  localparam logic [1:0]  LastAddrByte   = 2'd2;
  localparam logic [1:0]  LastDataByte   = 2'd3;
  localparam logic [23:0] LastWordAddr   = 24'hFFFFFC;

  // Address bytes go out MSB first.
  function automatic logic [7:0] addr_byte(logic [23:0] addr, logic [1:0] idx);
    case (idx)
      2'd0:    return addr[23:16];
      2'd1:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Bus-side request/response and SPI-controller signals of the flash read engine.
interface spi_flash_reader_if;
  logic        bus_valid;
  logic [23:0] bus_addr;
  logic        bus_ready;
  logic [31:0] bus_data;
  logic [7:0]  spi_tx;
  logic        spi_valid;
  logic        spi_ready;
  logic [7:0]  spi_rx;
  logic        spi_csn;

  // master: the read engine; slave: bus decoder plus SPI controller side.
  modport master (
    input  bus_valid, bus_addr, spi_ready, spi_rx,
    output bus_ready, bus_data, spi_tx, spi_valid, spi_csn
  );

  modport slave (
    output bus_valid, bus_addr, spi_ready, spi_rx,
    input  bus_ready, bus_data, spi_tx, spi_valid, spi_csn
  );
endinterface

// File: rtl/spi_byte_xfer.sv
// One-byte handshake with the byte-wide SPI controller: issue, wait busy, wait idle.
module spi_byte_xfer
  import spi_flash_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       spi_ready,
  input  logic [7:0] spi_rx,
  output logic       spi_valid,
  output logic [7:0] spi_tx,
  output logic       done,
  output logic [7:0] rx
);

  byte_state_e state_q, state_d;
  logic [7:0]  tx_q;
  logic        fire;

  assign fire = (state_q == StIssue) && start && spi_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIssue;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_q <= 8'h00;
    end else if (fire) begin
      tx_q <= tx;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIssue:  if (fire) state_d = StWaitLo;
      StWaitLo: if (!spi_ready) state_d = StWaitHi;
      StWaitHi: if (spi_ready) state_d = StIssue;
      default:  state_d = StIssue;
    endcase
  end

  // Before the start pulse the live byte is shown so it is already stable at spi_valid.
  always_comb begin
    spi_valid = fire;
    spi_tx    = (state_q == StIssue) ? tx : tx_q;
    done      = (state_q == StWaitHi) && spi_ready;
    rx        = spi_rx;
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Turns 32-bit bus reads into SPI-flash READ transactions, streaming sequential words.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0]  CMD_READ    = CmdReadDefault,
  parameter int unsigned CS_GAP      = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  spi_flash_reader_if.master bus
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GapW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(CS_GAP - 1);

  main_state_e      state_q, state_d;
  logic [23:0]      addr_q, next_q;
  logic             next_ok_q;
  logic [1:0]       cnt_q;
  logic [HoldW-1:0] hold_q;
  logic [GapW-1:0]  gap_q;
  logic [23:0]      shift_q;
  logic [31:0]      data_q;

  logic        start, done, seq_hit, csn, ready;
  logic [7:0]  tx_byte, rx_byte;
  logic [23:0] req_addr;
  logic        unused_addr_bits;

  assign req_addr         = {bus.bus_addr[23:2], 2'b00};
  assign unused_addr_bits = ^bus.bus_addr[1:0];
  // A wrapped next address is never sequential, so it always forces a fresh command.
  assign seq_hit          = bus.bus_valid && next_ok_q && (req_addr == next_q);

  spi_byte_xfer u_byte_xfer (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tx        (tx_byte),
    .spi_ready (bus.spi_ready),
    .spi_rx    (bus.spi_rx),
    .spi_valid (bus.spi_valid),
    .spi_tx    (bus.spi_tx),
    .done      (done),
    .rx        (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.bus_valid) state_d = StCmd;
      StCmd:  if (done) state_d = StAddr;
      StAddr: if (done && cnt_q == LastAddrByte) state_d = StData;
      StData: if (done && cnt_q == LastDataByte) state_d = StDone;
      StDone: state_d = (HOLD_CYCLES == 0) ? StGap : StHold;
      StHold: begin
        // A request in the timeout cycle wins over the timeout.
        if (bus.bus_valid) begin
          state_d = seq_hit ? StData : StGap;
        end else if (hold_q == HoldLast) begin
          state_d = StGap;
        end
      end
      StGap:   if (gap_q == GapLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    tx_byte = 8'h00;
    csn     = 1'b1;
    ready   = 1'b0;
    unique case (state_q)
      StCmd: begin
        start   = 1'b1;
        tx_byte = CMD_READ;
        csn     = 1'b0;
      end
      StAddr: begin
        start   = 1'b1;
        tx_byte = addr_byte(addr_q, cnt_q);
        csn     = 1'b0;
      end
      StData: begin
        start   = 1'b1;
        tx_byte = DummyByte;
        csn     = 1'b0;
      end
      StDone: begin
        csn   = 1'b0;
        ready = bus.bus_valid;
      end
      StHold:  csn = 1'b0;
      default: ;
    endcase
  end

  assign bus.spi_csn   = csn;
  assign bus.bus_ready = ready;
  assign bus.bus_data  = data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= 24'h0;
      next_q    <= 24'h0;
      next_ok_q <= 1'b0;
      cnt_q     <= 2'd0;
      hold_q    <= '0;
      gap_q     <= '0;
      shift_q   <= 24'h0;
      data_q    <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.bus_valid) addr_q <= req_addr;
          cnt_q <= 2'd0;
        end
        StAddr: begin
          if (done) cnt_q <= (cnt_q == LastAddrByte) ? 2'd0 : cnt_q + 2'd1;
        end
        StData: begin
          if (done) begin
            shift_q <= {rx_byte, shift_q[23:8]};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == LastDataByte) data_q <= {rx_byte, shift_q};
          end
        end
        StDone: begin
          next_q    <= addr_q + 24'd4;
          next_ok_q <= (addr_q != LastWordAddr);
          hold_q    <= '0;
          gap_q     <= '0;
        end
        StHold: begin
          hold_q <= hold_q + 1'b1;
          gap_q  <= '0;
          if (seq_hit) addr_q <= next_q;
        end
        StGap:   gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
